// File: rtl/fir_out_decimator_if.sv
// Output-side bus of the FIR decimator stage.
//   valid_in / y_in      : FIR result strobe and value (producer -> decimator)
//   out_valid / out_ready: valid/ready handshake for the decimated samples
//   out_data             : decimated, rounded, saturated sample
//   sat_flag / drop_count: sticky overflow and FIFO-drop statistics
// modport slave is the decimator; modport master is its environment.
interface fir_out_decimator_if #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 8
);
  logic             valid_in;
  logic [IN_W-1:0]  y_in;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             sat_flag;
  logic [7:0]       drop_count;

  modport slave (
    input  valid_in, y_in, out_ready,
    output out_valid, out_data, sat_flag, drop_count
  );

  modport master (
    output valid_in, y_in, out_ready,
    input  out_valid, out_data, sat_flag, drop_count
  );
endinterface

// File: rtl/fir_out_decimator.sv
// Downstream stage of the FIR filter: keeps one valid sample in every DECIM,
// rounds it (half up), shifts right by SHIFT, saturates to OUT_W bits and
// queues it in a small show-ahead FIFO behind a valid/ready port.
// Ports:
//   i_clock : rising-edge clock
//   i_reset : synchronous, active-high reset
//   bus     : fir_out_decimator_if.slave (input strobe/data, output handshake,
//             sticky sat_flag, saturating drop_count)
module fir_out_decimator #(
  parameter int IN_W       = 19,
  parameter int OUT_W      = 8,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  fir_out_decimator_if.slave   bus
);

  localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [IN_W:0]    RND   = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [IN_W:0]    QMAX  = (IN_W + 1)'((1 << OUT_W) - 1);
  localparam logic [PH_W-1:0]  PH_MAX = PH_W'(DECIM - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  // Sum is one bit wider than the input so the rounding constant never wraps.
  function automatic logic [IN_W:0] round_half_up(input logic [IN_W-1:0] y);
    logic [IN_W:0] sum;
    sum = {1'b0, y} + RND;
    return sum >> SHIFT;
  endfunction

  // Returns {saturated, value}.
  function automatic logic [OUT_W:0] saturate(input logic [IN_W:0] q);
    if (q > QMAX) return {1'b1, {OUT_W{1'b1}}};
    else          return {1'b0, q[OUT_W-1:0]};
  endfunction

  logic [PH_W-1:0]  r_phase;
  logic [LVL_W-1:0] r_level;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [OUT_W-1:0] r_mem [FIFO_DEPTH];
  logic [OUT_W-1:0] r_out_data;
  logic             r_sat_flag;
  logic [7:0]       r_drop_count;

  logic             w_vld_p0;
  logic [OUT_W:0]   w_rs;
  logic [OUT_W-1:0] w_result;
  logic             w_sat;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [PTR_W-1:0] w_rd_next;
  logic [LVL_W-1:0] w_level_next;
  logic [OUT_W-1:0] w_head_next;

  // Stage p0: decimation, rounding/saturation, FIFO admission
  assign w_vld_p0 = bus.valid_in && (r_phase == '0);
  assign w_rs     = saturate(round_half_up(bus.y_in));
  assign w_result = w_rs[OUT_W-1:0];
  assign w_sat    = w_rs[OUT_W];

  assign w_full = (r_level == LVL_FULL);
  assign w_pop  = (r_level != '0) && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push = w_vld_p0 && (!w_full || w_pop);
  assign w_drop = w_vld_p0 && w_full && !w_pop;

  assign w_rd_next = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop)      w_level_next = r_level + LVL_W'(1);
    else if (!w_push && w_pop) w_level_next = r_level - LVL_W'(1);
  end

  // The next head is the entry being written this edge only when the write
  // slot is where the read pointer lands (FIFO empty after this edge's pop).
  assign w_head_next = (w_push && (r_wr_ptr == w_rd_next)) ? w_result
                                                           : r_mem[w_rd_next];

  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= w_result;
  end

  // Stage p1: registered FIFO state and output port
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_phase      <= '0;
      r_level      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_out_data   <= '0;
      r_sat_flag   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (bus.valid_in) r_phase <= (r_phase == PH_MAX) ? '0 : r_phase + PH_W'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr <= w_rd_next;
      r_level  <= w_level_next;
      // Holds the last shown value while the FIFO is empty.
      if (w_level_next != '0) r_out_data <= w_head_next;
      if (w_vld_p0 && w_sat) r_sat_flag <= 1'b1;
      if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
    end
  end

  assign bus.out_valid  = (r_level != '0);
  assign bus.out_data   = r_out_data;
  assign bus.sat_flag   = r_sat_flag;
  assign bus.drop_count = r_drop_count;

endmodule

// File: tb/tb_fir_out_decimator.sv
module tb_fir_out_decimator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_out_decimator_if #(.IN_W(19), .OUT_W(8)) bus ();

  fir_out_decimator #(
    .IN_W(19), .OUT_W(8), .SHIFT(8), .DECIM(4), .FIFO_DEPTH(4)
  ) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int exp_q[$];
  int last_data = 0;
  int m_phase   = 0;
  int m_sat     = 0;
  int m_drop    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: round half up by integer division, then clamp to 8 bits.
  function automatic int ref_scale(input int y);
    return (y + 128) / 256;
  endfunction

  // One clock: drive inputs, check outputs at the falling edge, then advance
  // the model to what the DUT should show after the coming rising edge.
  task automatic step(input logic vin, input logic [18:0] y, input logic rdy);
    bit pop;
    int e;
    bus.valid_in  = vin;
    bus.y_in      = y;
    bus.out_ready = rdy;
    @(negedge clk);
    check("out_valid", bus.out_valid, (exp_q.size() != 0));
    if (exp_q.size() != 0) check("out_data", bus.out_data, exp_q[0]);
    else                   check("out_data_hold", bus.out_data, last_data);
    check("sat_flag", bus.sat_flag, m_sat);
    check("drop_count", bus.drop_count, m_drop);
    pop = (exp_q.size() != 0) && rdy;
    if (pop) last_data = exp_q.pop_front();
    if (vin && m_phase == 0) begin
      e = ref_scale(int'(y));
      if (e > 255) begin
        m_sat = 1;
        e = 255;
      end
      if (exp_q.size() < 4) exp_q.push_back(e);
      else if (m_drop < 255) m_drop++;
    end
    if (vin) m_phase = (m_phase + 1) % 4;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.valid_in  = 1'($urandom_range(0, 1));
      bus.y_in      = 19'($urandom());
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_sat_flag", bus.sat_flag, 0);
    check("rst_drop_count", bus.drop_count, 0);
    rst = 1'b0;
    bus.valid_in  = 1'b0;
    bus.out_ready = 1'b0;
    exp_q.delete();
    last_data = 0;
    m_phase = 0;
    m_sat = 0;
    m_drop = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.valid_in  = 1'b0;
    bus.y_in      = '0;
    bus.out_ready = 1'b0;

    // Reset with random inputs
    do_reset(2);

    // Basic decimation and rounding: expect 1 then 2
    begin
      int seq[8] = '{383, 1, 1, 1, 384, 1, 1, 1};
      for (int i = 0; i < 8; i++) step(1'b1, 19'(seq[i]), 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 19'd0, 1'b1);
    end

    // Saturation and sticky flag
    step(1'b1, 19'h7FFFF, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 19'd0, 1'b1);
    check("t3_sat_sticky", bus.sat_flag, 1);
    do_reset(1);

    // Fill with ready low: 6 kept samples, 2 dropped
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 19'(256 * k), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 19'd5, 1'b0);
    end
    check("t4_drop", bus.drop_count, 2);
    for (int i = 0; i < 6; i++) step(1'b0, 19'd0, 1'b1);
    do_reset(1);

    // Full FIFO, push and pop in the same cycle: no drop
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 19'(256 * k), 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 19'd0, 1'b0);
    end
    step(1'b1, 19'd2560, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 19'd0, 1'b1);
    check("t5_no_drop", bus.drop_count, 0);
    check("t5_last", bus.out_data, 10);

    // Irregular valid_in with random back-pressure
    for (int b = 0; b < 60; b++) begin
      int gap;
      logic [18:0] y;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) step(1'b0, 19'($urandom()), 1'($urandom_range(0, 3) != 0));
      y = ($urandom_range(0, 9) == 0) ? 19'($urandom()) : 19'($urandom_range(0, 60000));
      step(1'b1, y, 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 19'd0, 1'b1);

    // Reset with two entries queued, then the next valid beat is kept
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b1, (i % 4 == 0) ? 19'd256 : 19'd0, 1'b0);
    check("t6_queued_valid", bus.out_valid, 1);
    do_reset(1);
    step(1'b1, 19'd768, 1'b1);
    check("t6_kept_after_rst", bus.out_data, 3);
    for (int i = 0; i < 3; i++) step(1'b0, 19'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
